flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer side of the 4-bit {N,Z,C,V} flags bus consumed by the condition checker.
- Derives NZCV from the ALU operands and result, qualifies the write with FlagW and the current instruction's CondEx, and stages the update through a one-entry pending register before committing it to the architectural flag register.
- Provides a forwarded flag view so a back-to-back conditional instruction sees the newest flags.

Parameters:
WIDTH, 32, ALU datapath width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (asserted when 0)
InValid  input  1  an instruction is presented in EX this cycle
ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
SrcA  input  WIDTH  ALU operand A
SrcB  input  WIDTH  ALU operand B
Result  input  WIDTH  ALU result
CarryOut  input  1  ALU adder carry-out (SUB: 1 = no borrow)
FlagW  input  2  [1] write N,Z group; [0] write C,V group
CondEx  input  1  condition result for this instruction from the checker
Stall  input  1  freeze both stages
Flush  input  1  kill pending (uncommitted) update
ALUFlags  output  4  raw combinational {N,Z,C,V} of current inputs
Flags  output  4  architectural {N,Z,C,V} register
FlagsFwd  output  4  Flags merged with pending update (per group)
FlagsCommit  output  1  one-cycle pulse when pending update commits

Behaviour:
- Reset (reset=0, async): Flags=4'b0000, pending valid=0, pending mask=00, FlagsCommit=0; FlagsFwd therefore 0000.
- Raw flags, combinational, msb = WIDTH-1:
  - N = Result[msb]; Z = (Result == 0).
  - ADD: C = CarryOut; V = (SrcA[msb]==SrcB[msb]) & (Result[msb]!=SrcA[msb]).
  - SUB: C = CarryOut; V = (SrcA[msb]!=SrcB[msb]) & (Result[msb]!=SrcA[msb]).
  - AND/ORR: C=0, V=0.
- Capture (stage 1), rising edge, Stall=0, Flush=0:
  - If InValid & CondEx & (FlagW!=00): pending valid<=1, pending flags<=ALUFlags, pending mask<=FlagW.
  - Otherwise pending valid<=0.
- Commit (stage 2), same edge, Stall=0, Flush=0, pending valid=1:
  - Flags[3:2] <= pending[3:2] if mask[1].
  - Flags[1:0] <= pending[1:0] if mask[0].
  - FlagsCommit<=1; otherwise FlagsCommit<=0.
  - Commit and capture occur on the same edge, so a continuous stream commits one update per cycle with no bubbles.
- Latency:
  - ALUFlags: 0 cycles.
  - FlagsFwd: reflects an update 1 edge after capture.
  - Flags: reflects an update 2 edges after capture.
- FlagsFwd = pending valid ? per-group merge (masked groups from pending, others from Flags) : Flags. Combinational from registers only; no path from ALU inputs.
- Stall=1, Flush=0: all registers hold; FlagsCommit<=0; InValid ignored.
- Flush=1: pending valid<=0 and no commit this edge (pending entry discarded); Flags hold; FlagsCommit<=0; capture suppressed. Flush has priority over Stall.
- Masked group not written: the group is unaffected in both pending merge and commit; no glitch on FlagsFwd.
- CondEx=0: no flag write even with FlagW!=00.
- Reset mid-operation: pending entry lost, Flags cleared immediately (no clock needed).
- X on ALUControl with a write enabled is illegal; the bench asserts against it.

Optional Feature:
FLAG_UNIT_STATS_EN
- Defined: adds output CommitCount [15:0], reset 0, incremented on every edge where FlagsCommit is set to 1; saturates at 16'hFFFF (no wrap). Also adds output FlushDrops [7:0], counting flushes that discarded a valid pending entry, saturating at 8'hFF.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then idle → Flags=0000, FlagsFwd=0000, FlagsCommit=0 for 10 cycles.
- WIDTH=32, SUB, SrcA=5, SrcB=5, Result=0, CarryOut=1, FlagW=11, CondEx=1, InValid=1 → ALUFlags=0110; FlagsFwd=0110 after edge 1; Flags=0110 and FlagsCommit=1 after edge 2.
- ADD 0x7FFFFFFF+1, Result=0x80000000, CarryOut=0, FlagW=11 → ALUFlags=1001; Flags=1001 after 2 edges. Then AND, Result=0, FlagW=10 → Flags=0101 (C,V preserved).
- Same SUB as test 2 but CondEx=0 → Flags and FlagsFwd unchanged, FlagsCommit never 1.
- Capture an update, assert Flush on the next edge → FlagsFwd reverts to old Flags, Flags unchanged, FlagsCommit=0 (with FLAG_UNIT_STATS_EN: FlushDrops=1).
- Capture, then Stall=1 for 3 cycles → pending held, FlagsFwd shows the update, Flags old; Flags updates on the first edge after Stall drops. Assert reset mid-stall → all outputs 0 asynchronously.

Source files
------------

// File: rtl/flag_unit.sv
// NZCV flag producer: raw flag derivation, one-entry pending stage, architectural commit.
// Optional FLAG_UNIT_STATS_EN adds CommitCount/FlushDrops saturating counters.
module flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] Result,
  input  logic             CarryOut,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             Stall,
  input  logic             Flush,
  output logic [3:0]       ALUFlags,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsFwd,
  output logic             FlagsCommit
`ifdef FLAG_UNIT_STATS_EN
  ,
  output logic [15:0]      CommitCount,
  output logic [7:0]       FlushDrops
`endif
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [3:0] r_flags;
  logic       r_pend_vld;
  logic [3:0] r_pend_flags;
  logic [1:0] r_pend_mask;
  logic       r_commit;

  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_capture;
  logic [3:0] w_merged;

  // Raw flags from the current ALU operands/result
  always_comb begin
    w_n = Result[MSB];
    w_z = (Result == '0);
    w_c = 1'b0;
    w_v = 1'b0;
    unique case (ALUControl)
      2'b00: begin
        w_c = CarryOut;
        w_v = (SrcA[MSB] == SrcB[MSB]) & (Result[MSB] != SrcA[MSB]);
      end
      2'b01: begin
        w_c = CarryOut;
        w_v = (SrcA[MSB] != SrcB[MSB]) & (Result[MSB] != SrcA[MSB]);
      end
      default: begin
        w_c = 1'b0;
        w_v = 1'b0;
      end
    endcase
  end

  assign ALUFlags  = {w_n, w_z, w_c, w_v};
  assign w_capture = InValid & CondEx & (FlagW != 2'b00);

  // Per-group merge of the pending entry over the architectural flags
  assign w_merged = {r_pend_mask[1] ? r_pend_flags[3:2] : r_flags[3:2],
                     r_pend_mask[0] ? r_pend_flags[1:0] : r_flags[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags      <= 4'b0000;
      r_pend_vld   <= 1'b0;
      r_pend_flags <= 4'b0000;
      r_pend_mask  <= 2'b00;
      r_commit     <= 1'b0;
    end else if (Flush) begin
      r_pend_vld <= 1'b0;
      r_commit   <= 1'b0;
    end else if (Stall) begin
      r_commit <= 1'b0;
    end else begin
      r_pend_vld <= w_capture;
      if (w_capture) begin
        r_pend_flags <= ALUFlags;
        r_pend_mask  <= FlagW;
      end
      if (r_pend_vld) begin
        r_flags <= w_merged;
      end
      r_commit <= r_pend_vld;
    end
  end

  assign Flags       = r_flags;
  assign FlagsFwd    = r_pend_vld ? w_merged : r_flags;
  assign FlagsCommit = r_commit;

`ifdef FLAG_UNIT_STATS_EN
  logic [15:0] r_commit_cnt;
  logic [7:0]  r_flush_drops;

  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_commit_cnt  <= 16'h0000;
      r_flush_drops <= 8'h00;
    end else begin
      if (!Flush && !Stall && r_pend_vld && (r_commit_cnt != 16'hFFFF)) begin
        r_commit_cnt <= r_commit_cnt + 16'd1;
      end
      if (Flush && r_pend_vld && (r_flush_drops != 8'hFF)) begin
        r_flush_drops <= r_flush_drops + 8'd1;
      end
    end
  end

  assign CommitCount = r_commit_cnt;
  assign FlushDrops  = r_flush_drops;
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios then randomized traffic vs. a reference model.
module tb_flag_unit;

  localparam int unsigned WIDTH = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic             clk;
  logic             reset;
  logic             InValid;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Result;
  logic             CarryOut;
  logic [1:0]       FlagW;
  logic             CondEx;
  logic             Stall;
  logic             Flush;
  logic [3:0]       ALUFlags;
  logic [3:0]       Flags;
  logic [3:0]       FlagsFwd;
  logic             FlagsCommit;
`ifdef FLAG_UNIT_STATS_EN
  logic [15:0]      CommitCount;
  logic [7:0]       FlushDrops;
`endif

  flag_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .Result(Result), .CarryOut(CarryOut),
    .FlagW(FlagW), .CondEx(CondEx), .Stall(Stall), .Flush(Flush),
    .ALUFlags(ALUFlags), .Flags(Flags), .FlagsFwd(FlagsFwd), .FlagsCommit(FlagsCommit)
`ifdef FLAG_UNIT_STATS_EN
    , .CommitCount(CommitCount), .FlushDrops(FlushDrops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural flags plus an at-most-one-entry pending list
  logic [3:0] m_flags;
  logic [3:0] q_flags[$];
  logic [1:0] q_mask[$];
  logic       m_commit;
  int         m_cc;
  int         m_fd;
  logic [3:0] exp_raw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset && InValid && CondEx && (FlagW != 2'b00)) begin
      assert (!$isunknown(ALUControl)) else begin
        bad++;
        $error("FAIL alucontrol_x observed=%b expected=known", ALUControl);
      end
    end
  end

  function automatic logic [3:0] apply(input logic [3:0] base, input logic [3:0] upd,
                                       input logic [1:0] mask);
    logic [3:0] r;
    r = base;
    if (mask[1]) begin r[3] = upd[3]; r[2] = upd[2]; end
    if (mask[0]) begin r[1] = upd[1]; r[0] = upd[0]; end
    return r;
  endfunction

  function automatic logic [3:0] fwd_view();
    if (q_flags.size() == 0) return m_flags;
    return apply(m_flags, q_flags[0], q_mask[0]);
  endfunction

  // Compute result/carry/NZCV from operands with wide integer arithmetic
  task automatic alu_ref(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic cout, output logic [3:0] fl);
    longint ua, ub, sa, sb, u, s;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (ctl)
      2'b00: begin
        u = ua + ub; s = sa + sb;
        res = 32'(u); cout = (u > UMAX); c = cout; v = (s > SMAX) || (s < SMIN);
      end
      2'b01: begin
        u = ua - ub; s = sa - sb;
        res = 32'(u); cout = (ua >= ub); c = cout; v = (s > SMAX) || (s < SMIN);
      end
      2'b10: begin res = a & b; cout = 1'($urandom_range(1, 0)); end
      default: begin res = a | b; cout = 1'($urandom_range(1, 0)); end
    endcase
    fl = {res[31], (res == 32'd0), c, v};
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fw, input logic ce, input logic vld,
                       input logic st, input logic fl);
    logic [31:0] res;
    logic        co;
    alu_ref(ctl, a, b, res, co, exp_raw);
    ALUControl = ctl; SrcA = a; SrcB = b; Result = res; CarryOut = co;
    FlagW = fw; CondEx = ce; InValid = vld; Stall = st; Flush = fl;
    #1;
    chk("aluflags", 32'(ALUFlags), 32'(exp_raw));
  endtask

  task automatic idle();
    drive(2'b10, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_commit = 1'b0; m_cc = 0; m_fd = 0;
    q_flags.delete(); q_mask.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_flags"},  32'(Flags),       32'(m_flags));
    chk({tag, "_fwd"},    32'(FlagsFwd),    32'(fwd_view()));
    chk({tag, "_commit"}, 32'(FlagsCommit), 32'(m_commit));
`ifdef FLAG_UNIT_STATS_EN
    chk({tag, "_ccount"}, 32'(CommitCount), 32'(m_cc));
    chk({tag, "_fdrops"}, 32'(FlushDrops),  32'(m_fd));
`endif
  endtask

  // One clock edge: advance the reference with the inputs present at the edge, then compare
  task automatic tick(input string tag);
    @(posedge clk);
    if (Flush) begin
      if (q_flags.size() != 0 && m_fd < 255) m_fd++;
      q_flags.delete(); q_mask.delete();
      m_commit = 1'b0;
    end else if (Stall) begin
      m_commit = 1'b0;
    end else begin
      m_commit = 1'b0;
      if (q_flags.size() != 0) begin
        m_flags  = apply(m_flags, q_flags.pop_front(), q_mask.pop_front());
        m_commit = 1'b1;
        if (m_cc < 65535) m_cc++;
      end
      if (InValid && CondEx && (FlagW != 2'b00)) begin
        q_flags.push_back(exp_raw);
        q_mask.push_back(FlagW);
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] corner[4];
    corner[0] = 32'h0000_0000; corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'h8000_0000; corner[3] = 32'hFFFF_FFFF;

    reset = 1'b0;
    ALUControl = 2'b10; SrcA = '0; SrcB = '0; Result = '0; CarryOut = 1'b0;
    FlagW = 2'b00; CondEx = 1'b0; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Idle after reset
    idle();
    for (int i = 0; i < 10; i++) tick("idle");

    // SUB 5-5: N=0 Z=1 C=1 V=0
    drive(2'b01, 32'd5, 32'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sub_raw_const", 32'(ALUFlags), 32'h6);
    tick("sub_e1");
    chk("sub_fwd_const", 32'(FlagsFwd), 32'h6);
    idle();
    tick("sub_e2");
    chk("sub_flags_const", 32'(Flags), 32'h6);
    chk("sub_commit_const", 32'(FlagsCommit), 32'h1);
    tick("sub_e3");

    // ADD signed overflow, then AND writing only N,Z
    drive(2'b00, 32'h7FFF_FFFF, 32'd1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("add_raw_const", 32'(ALUFlags), 32'h9);
    tick("add_e1");
    idle();
    tick("add_e2");
    chk("add_flags_const", 32'(Flags), 32'h9);
    drive(2'b10, 32'd0, 32'd0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("and_e1");
    idle();
    tick("and_e2");
    chk("and_flags_const", 32'(Flags), 32'h5);

    // CondEx=0 suppresses the write
    drive(2'b01, 32'd5, 32'd5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("condex0_e1");
    idle();
    tick("condex0_e2");
    chk("condex0_flags_const", 32'(Flags), 32'h5);
    tick("condex0_e3");

    // Flush discards the pending entry
    drive(2'b00, 32'd1, 32'd1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("flush_cap");
    chk("flush_cap_fwd_const", 32'(FlagsFwd), 32'h0);
    drive(2'b01, 32'd5, 32'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    tick("flush_e");
    chk("flush_fwd_const", 32'(FlagsFwd), 32'h5);
    idle();
    tick("flush_after");

    // Stall holds the pending entry; commit on first unstalled edge
    drive(2'b01, 32'd3, 32'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_raw_const", 32'(ALUFlags), 32'h8);
    tick("stall_cap");
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 32'h8000_0000, 32'h8000_0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      tick("stall_hold");
      chk("stall_fwd_const", 32'(FlagsFwd), 32'h8);
      chk("stall_flags_const", 32'(Flags), 32'h5);
    end
    idle();
    tick("stall_release");
    chk("stall_release_const", 32'(Flags), 32'h8);

    // Reset asserted mid-stall clears everything without a clock
    drive(2'b00, 32'h8000_0000, 32'h8000_0000, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("rst_cap");
    drive(2'b10, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("rst_stall");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    idle();
    tick("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 32'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 32'($urandom);
      if ($urandom_range(7, 0) == 0) rb = ra;
      drive(2'($urandom_range(3, 0)), ra, rb, 2'($urandom_range(3, 0)),
            1'($urandom_range(3, 0) != 0), 1'($urandom_range(4, 0) != 0),
            1'($urandom_range(9, 0) == 0), 1'($urandom_range(9, 0) == 0));
      tick("rand");
    end
    idle();
    tick("drain1");
    tick("drain2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
